// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions: field layout, exponent
// constants and the fp2int_unit FSM states.
package fp_pkg;

   localparam int unsigned EXP_BIAS   = 127;
   localparam logic [7:0]  FP_EXP_MAX = 8'd255;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_SHIFT,
      ST_FINISH,
      ST_DONE
   } fp2int_state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational special-value detection for a packed single-precision word.
module fp_classify
   import fp_pkg::*;
(
   input  fp32_t op,
   output logic  is_nan,
   output logic  is_inf,
   output logic  is_zero,
   output logic  is_denorm
);

   logic exp_max;
   logic exp_min;
   logic frac_nz;

   assign exp_max   = (op.exp == FP_EXP_MAX);
   assign exp_min   = (op.exp == 8'd0);
   assign frac_nz   = (op.frac != 23'd0);

   assign is_nan    = exp_max &  frac_nz;
   assign is_inf    = exp_max & ~frac_nz;
   assign is_zero   = exp_min & ~frac_nz;
   assign is_denorm = exp_min &  frac_nz;

endmodule

// File: rtl/fp2int_unit.sv
// Iterative float32 -> signed INT_W converter, one significand shift per cycle.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp2int_unit #(
   parameter int unsigned INT_W    = 32,
   parameter int unsigned EXP_BIAS = fp_pkg::EXP_BIAS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      dataA,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INT_W-1:0] dataR,
   output logic             flag_invalid,
   output logic             flag_overflow,
   output logic             flag_inexact
);

   import fp_pkg::*;

   localparam int unsigned       MAG_W     = ((INT_W > 24) ? INT_W : 24) + 1;
   localparam logic [INT_W-1:0]  POS_MAX   = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0]  NEG_MIN   = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic [MAG_W-1:0]  MAG_LIMIT = MAG_W'(1) << (INT_W - 1);
   localparam logic signed [9:0] E_SAT     = 10'(INT_W - 1);

   fp2int_state_e state_q, state_d;

   fp32_t            op_q;
   logic             sign_q;
   logic [MAG_W-1:0] mag_q;
   logic             guard_q, sticky_q, left_q;
   logic [4:0]       cnt_q;
   logic             fixed_q;
   logic [INT_W-1:0] fixed_val_q;
   logic             invalid_q, overflow_q, inexact_q;

   logic is_nan, is_inf, is_zero, is_denorm;

   fp_classify u_classify (
      .op        (op_q),
      .is_nan    (is_nan),
      .is_inf    (is_inf),
      .is_zero   (is_zero),
      .is_denorm (is_denorm)
   );

   logic signed [9:0] e_v;
   assign e_v = $signed({2'b00, op_q.exp}) - $signed(10'(EXP_BIAS));

   // Unpack decode: special results bypass the shifter through the fixed_* path.
   logic             u_fixed, u_inv, u_ovf, u_inex, u_guard, u_sticky, u_left;
   logic [INT_W-1:0] u_fixed_val;
   logic [MAG_W-1:0] u_mag;
   logic [4:0]       u_cnt;

   always_comb begin
      u_fixed     = 1'b0;
      u_fixed_val = '0;
      u_inv       = 1'b0;
      u_ovf       = 1'b0;
      u_inex      = 1'b0;
      u_guard     = 1'b0;
      u_sticky    = 1'b0;
      u_left      = 1'b0;
      u_cnt       = '0;
      u_mag       = '0;
      u_mag[23:0] = {1'b1, op_q.frac};
      if (is_nan) begin
         u_fixed     = 1'b1;
         u_fixed_val = POS_MAX;
         u_inv       = 1'b1;
      end else if (is_inf) begin
         u_fixed     = 1'b1;
         u_fixed_val = op_q.sign ? NEG_MIN : POS_MAX;
         u_ovf       = 1'b1;
      end else if (is_zero || is_denorm) begin
         u_mag    = '0;
         u_sticky = is_denorm;
      end else if (e_v < 10'sd0) begin
         u_mag    = '0;
         u_guard  = (e_v == -10'sd1);
         u_sticky = (op_q.frac != 23'd0);
         u_inex   = 1'b1;
      end else if (e_v >= E_SAT) begin
         u_fixed = 1'b1;
         if (op_q.sign && (e_v == E_SAT) && (op_q.frac == 23'd0)) begin
            u_fixed_val = NEG_MIN;
         end else begin
            u_fixed_val = op_q.sign ? NEG_MIN : POS_MAX;
            u_ovf       = 1'b1;
         end
      end else if (e_v < 10'sd23) begin
         u_cnt = 5'(10'sd23 - e_v);
      end else if (e_v > 10'sd23) begin
         u_cnt  = 5'(e_v - 10'sd23);
         u_left = 1'b1;
      end
   end

   logic             rnd_inc;
   logic [MAG_W-1:0] mag_rnd;
   logic [INT_W-1:0] f_res;
   logic             f_ovf;

   always_comb begin
`ifdef FP2INT_ROUND_NEAREST_EN
      rnd_inc = guard_q & (sticky_q | mag_q[0]);
`else
      rnd_inc = 1'b0;
`endif
      mag_rnd = mag_q + MAG_W'(rnd_inc);
      f_res   = '0;
      f_ovf   = overflow_q;
      if (fixed_q) begin
         f_res = fixed_val_q;
      end else if (!sign_q && (mag_rnd >= MAG_LIMIT)) begin
         f_res = POS_MAX;
         f_ovf = 1'b1;
      end else if (sign_q) begin
         f_res = -mag_rnd[INT_W-1:0];
      end else begin
         f_res = mag_rnd[INT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid) state_d = ST_UNPACK;
         ST_UNPACK: state_d = (u_fixed || (u_cnt == 5'd0)) ? ST_FINISH : ST_SHIFT;
         ST_SHIFT:  if (cnt_q == 5'd1) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_DONE;
         ST_DONE:   if (out_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q          <= '0;
         sign_q        <= 1'b0;
         mag_q         <= '0;
         guard_q       <= 1'b0;
         sticky_q      <= 1'b0;
         left_q        <= 1'b0;
         cnt_q         <= '0;
         fixed_q       <= 1'b0;
         fixed_val_q   <= '0;
         invalid_q     <= 1'b0;
         overflow_q    <= 1'b0;
         inexact_q     <= 1'b0;
         dataR         <= '0;
         flag_invalid  <= 1'b0;
         flag_overflow <= 1'b0;
         flag_inexact  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid) op_q <= dataA;
            ST_UNPACK: begin
               sign_q      <= op_q.sign;
               mag_q       <= u_mag;
               guard_q     <= u_guard;
               sticky_q    <= u_sticky;
               left_q      <= u_left;
               cnt_q       <= u_cnt;
               fixed_q     <= u_fixed;
               fixed_val_q <= u_fixed_val;
               invalid_q   <= u_inv;
               overflow_q  <= u_ovf;
               inexact_q   <= u_inex;
            end
            ST_SHIFT: begin
               cnt_q <= cnt_q - 5'd1;
               if (left_q) begin
                  mag_q <= mag_q << 1;
               end else begin
                  mag_q    <= mag_q >> 1;
                  guard_q  <= mag_q[0];
                  sticky_q <= sticky_q | guard_q;
               end
            end
            ST_FINISH: begin
               dataR         <= f_res;
               flag_invalid  <= invalid_q;
               flag_overflow <= f_ovf;
               flag_inexact  <= inexact_q | guard_q | sticky_q;
            end
            default: ;
         endcase
      end
   end

endmodule
